// File: rtl/key_pad_emulator.sv
// key_pad_emulator: emulates a 4x3 key pad that presses a handshaked key code for a hold time, then releases it for a gap.
// Ports:
//   i_clk, i_rst_n        clock (rising edge) and asynchronous active-low reset
//   i_key, i_valid        key code 0-9, 10 = *, 11 = #; codes 12-15 are rejected with o_err
//   o_ready               idle and able to accept a code
//   o_err                 one-cycle pulse when an invalid code is offered while idle
//   i_col                 active-low column drive from the scanner (C1 = bit 2, C2 = bit 1, C3 = bit 0)
//   o_row                 registered active-low row return (R1 = bit 3 ... R4 = bit 0)
//   o_busy                high while pressing or releasing
//   o_done                one-cycle pulse on the last release cycle
// Optional macro KEY_PAD_BOUNCE_EN adds contact bounce at the start of press and release.
module key_pad_emulator #(
    parameter int CNT_W         = 18,
    parameter int HOLD_CYCLES   = 200000,
    parameter int GAP_CYCLES    = 200000,
    parameter int BOUNCE_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_err,
    input  logic [2:0] i_col,
    output logic [3:0] o_row,
    output logic       o_busy,
    output logic       o_done
);
    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic [3:0]       row_q, row_d;
    logic [2:0]       col_mask;
    logic [3:0]       row_pat;
    logic             hold_end, gap_end, contact;

    // Column mask marks the key's column bit; row_pat is the active-low row it shorts to.
    always_comb begin
        col_mask = 3'b000;
        row_pat  = 4'b1111;
        case (key_q)
            4'd1:  {col_mask, row_pat} = {3'b100, 4'b0111};
            4'd2:  {col_mask, row_pat} = {3'b010, 4'b0111};
            4'd3:  {col_mask, row_pat} = {3'b001, 4'b0111};
            4'd4:  {col_mask, row_pat} = {3'b100, 4'b1011};
            4'd5:  {col_mask, row_pat} = {3'b010, 4'b1011};
            4'd6:  {col_mask, row_pat} = {3'b001, 4'b1011};
            4'd7:  {col_mask, row_pat} = {3'b100, 4'b1101};
            4'd8:  {col_mask, row_pat} = {3'b010, 4'b1101};
            4'd9:  {col_mask, row_pat} = {3'b001, 4'b1101};
            4'd10: {col_mask, row_pat} = {3'b100, 4'b1110};
            4'd0:  {col_mask, row_pat} = {3'b010, 4'b1110};
            4'd11: {col_mask, row_pat} = {3'b001, 4'b1110};
            default: {col_mask, row_pat} = {3'b000, 4'b1111};
        endcase
    end

    assign hold_end = cnt_q == CNT_W'(HOLD_CYCLES - 1);
    assign gap_end  = cnt_q == CNT_W'(GAP_CYCLES - 1);

`ifdef KEY_PAD_BOUNCE_EN
    // Contact chatters with a period of 8 cycles while cnt is inside the bounce window.
    assign contact = (state_q == PRESS && (cnt_q >= CNT_W'(BOUNCE_CYCLES) || !cnt_q[2])) ||
                     (state_q == RELEASE && cnt_q < CNT_W'(BOUNCE_CYCLES) && cnt_q[2]);
`else
    // BOUNCE_CYCLES is only meaningful with bounce enabled; the term is always true here.
    assign contact = state_q == PRESS && BOUNCE_CYCLES >= 0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        case (state_q)
            IDLE: if (i_valid && i_key <= 4'd11) begin
                state_d = PRESS;
                cnt_d   = '0;
                key_d   = i_key;
            end
            PRESS: begin
                state_d = hold_end ? RELEASE : PRESS;
                cnt_d   = hold_end ? '0 : cnt_q + CNT_W'(1);
            end
            RELEASE: begin
                state_d = gap_end ? IDLE : RELEASE;
                cnt_d   = gap_end ? '0 : cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Other column bits are ignored so several low columns still return the row.
        row_d = (contact && (i_col & col_mask) == 3'b000) ? row_pat : 4'b1111;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 4'hF;
            row_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            row_q   <= row_d;
        end
    end

    assign o_row   = row_q;
    assign o_ready = state_q == IDLE;
    assign o_busy  = state_q != IDLE;
    assign o_err   = state_q == IDLE && i_valid && i_key > 4'd11;
    assign o_done  = state_q == RELEASE && gap_end;
endmodule
